// File: rtl/mac_serial_seq.sv
// Sequencer for the bit-serial MAC datapath.
// Accepts (w, a) operand pairs over a valid/ready handshake.
// Streams each weight LSB-first in N_WIDTH-bit chunks at the configured
// precision, and drives the MAC control strobes. z_valid pulses once the
// programmed number of operations has been flushed into the accumulator.
module mac_serial_seq #(
  parameter int W_WIDTH        = 8,
  parameter int A_WIDTH        = 8,
  parameter int N_WIDTH        = 2,
  parameter int CONFIG_W_WIDTH = 2,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CONFIG_W_WIDTH-1:0] config_w,
  input  logic [LEN_WIDTH-1:0]      acc_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W_WIDTH-1:0]        w_in,
  input  logic [A_WIDTH-1:0]        a_in,
  output logic                      mac_rst,
  output logic                      mac_en,
  output logic                      accu_en,
  output logic                      fsm_accu,
  output logic                      fsm_last,
  output logic [N_WIDTH-1:0]        w_serial,
  output logic [A_WIDTH-1:0]        a,
  output logic                      busy,
  output logic                      z_valid
);

  localparam int CHUNK_MAX = W_WIDTH / N_WIDTH;
  localparam int IDX_W     = $clog2(CHUNK_MAX + 1);
  localparam int SH_W      = $clog2(W_WIDTH + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLR    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_SHIFT  = 3'd3;
  localparam logic [2:0] ST_DRAIN1 = 3'd4;
  localparam logic [2:0] ST_DRAIN2 = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  logic [2:0]                state_q, state_d;
  logic [CONFIG_W_WIDTH-1:0] cfg_q, cfg_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      ops_q, ops_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [W_WIDTH-1:0]        sr_q, sr_d;
  logic [A_WIDTH-1:0]        a_q, a_d;

  logic [IDX_W-1:0]   chunks;
  logic [SH_W-1:0]    shamt;
  logic [LEN_WIDTH:0] ops_inc;
  logic               last_chunk;
  logic               more_ops;
  logic               handshake;

  // Chunk count and weight alignment shift for the latched precision
  // (cfg_q is normalised at latch time, so only 0, 1 and 3 reach here).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    chunks = IDX_W'(CHUNK_MAX / 4);
    shamt  = SH_W'(W_WIDTH - W_WIDTH / 4);
    if (cfg_q == CONFIG_W_WIDTH'(0)) begin
      chunks = IDX_W'(CHUNK_MAX);
      shamt  = '0;
    end else if (cfg_q == CONFIG_W_WIDTH'(1)) begin
      chunks = IDX_W'(CHUNK_MAX / 2);
      shamt  = SH_W'(W_WIDTH / 2);
    end
  end

  assign ops_inc    = {1'b0, ops_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign last_chunk = (idx_q == chunks - 1'b1);
  assign more_ops   = (ops_inc < {1'b0, len_q});
  assign handshake  = in_valid & in_ready;

  // Moore-style control outputs decoded from the current state and chunk index.
  always_comb begin
    mac_rst  = 1'b0;
    mac_en   = 1'b0;
    accu_en  = 1'b0;
    fsm_accu = 1'b0;
    fsm_last = 1'b0;
    in_ready = 1'b0;
    z_valid  = 1'b0;
    w_serial = '0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: mac_rst = 1'b1;
      ST_CLR: begin
        mac_rst = 1'b1;
        mac_en  = 1'b1;
        accu_en = 1'b1;
      end
      ST_WAIT: in_ready = 1'b1;
      ST_SHIFT: begin
        mac_en   = 1'b1;
        w_serial = sr_q[N_WIDTH-1:0];
        fsm_accu = (idx_q == '0);
        fsm_last = last_chunk;
        accu_en  = (idx_q == IDX_W'(1)) | (chunks == IDX_W'(1));
        in_ready = last_chunk & more_ops;
      end
      ST_DRAIN1: begin
        mac_en  = 1'b1;
        accu_en = 1'b1;
      end
      ST_DRAIN2: mac_en = 1'b1;
      ST_DONE:   z_valid = 1'b1;
      default:   mac_rst = 1'b1;
    endcase
  end

  assign a = a_q;

  // Next-state logic: batch setup, operand capture, chunk shifting and batch completion.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    len_d   = len_q;
    ops_d   = ops_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    a_d     = a_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d   = (config_w == CONFIG_W_WIDTH'(2)) ? CONFIG_W_WIDTH'(3) : config_w;
          len_d   = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
          ops_d   = '0;
          idx_d   = '0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_WAIT;
      ST_WAIT: begin
        if (handshake) begin
          sr_d    = w_in >> shamt;
          a_d     = a_in;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last_chunk) begin
          ops_d = ops_inc[LEN_WIDTH-1:0];
          if (handshake) begin
            // Back-to-back operation: reload without a bubble cycle.
            sr_d  = w_in >> shamt;
            a_d   = a_in;
            idx_d = '0;
          end else if (more_ops) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_DRAIN1;
          end
        end else begin
          sr_d  = sr_q >> N_WIDTH;
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN1: state_d = ST_DRAIN2;
      ST_DRAIN2: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      len_q   <= '0;
      ops_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      len_q   <= len_d;
      ops_q   <= ops_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      a_q     <= a_d;
    end
  end

endmodule

// File: tb/tb_mac_serial_seq.sv
// Directed bench for mac_serial_seq: per-cycle vector table plus a hand-written
// mid-operation reset sequence.
module tb_mac_serial_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] config_w;
  logic [7:0] acc_len;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] w_in;
  logic [7:0] a_in;
  logic       mac_rst;
  logic       mac_en;
  logic       accu_en;
  logic       fsm_accu;
  logic       fsm_last;
  logic [1:0] w_serial;
  logic [7:0] a;
  logic       busy;
  logic       z_valid;

  int n_pass;
  int n_total;

  mac_serial_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .config_w (config_w),
    .acc_len  (acc_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .w_in     (w_in),
    .a_in     (a_in),
    .mac_rst  (mac_rst),
    .mac_en   (mac_en),
    .accu_en  (accu_en),
    .fsm_accu (fsm_accu),
    .fsm_last (fsm_last),
    .w_serial (w_serial),
    .a        (a),
    .busy     (busy),
    .z_valid  (z_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {busy, mac_rst, mac_en, accu_en, fsm_accu, fsm_last, in_ready, z_valid, w_serial}
  localparam logic [9:0] E_IDLE = 10'b0100000000;
  localparam logic [9:0] E_CLR  = 10'b1111000000;
  localparam logic [9:0] E_WAIT = 10'b1000001000;
  localparam logic [9:0] E_D1   = 10'b1011000000;
  localparam logic [9:0] E_D2   = 10'b1010000000;
  localparam logic [9:0] E_DONE = 10'b1000000100;

  typedef struct {
    string      name;
    logic       st;
    logic [1:0] cfg;
    logic [7:0] len;
    logic       vld;
    logic [7:0] w;
    logic [7:0] aa;
    logic [9:0] exp_ctl;
    logic [7:0] exp_a;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] obs();
    return {busy, mac_rst, mac_en, accu_en, fsm_accu, fsm_last, in_ready, z_valid, w_serial};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic add(input string nm, input logic st, input logic [1:0] cfg, input logic [7:0] len,
                     input logic vld, input logic [7:0] w, input logic [7:0] aa,
                     input logic [9:0] e, input logic [7:0] ea);
    vec_t v;
    v.name = nm; v.st = st; v.cfg = cfg; v.len = len; v.vld = vld;
    v.w = w; v.aa = aa; v.exp_ctl = e; v.exp_a = ea;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    start = 1'b0; config_w = 2'd0; acc_len = 8'd0; in_valid = 1'b0; w_in = 8'h00; a_in = 8'h00;
  endtask

  int z_seen;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    drive_idle();

    // 8b, len=1: chunks 10,01,11,10; z_valid 3 cycles after last chunk.
    add("a_idle",  1, 2'd0, 8'd1, 0, 8'h00, 8'h00, E_IDLE, 8'h00);
    add("a_clr",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_CLR,  8'h00);
    add("a_wait",  0, 2'd0, 8'd0, 1, 8'hB6, 8'h5A, E_WAIT, 8'h00);
    add("a_sh0",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1010100010, 8'h5A);
    add("a_sh1",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1011000001, 8'h5A);
    add("a_sh2",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1010000011, 8'h5A);
    add("a_sh3",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1010010010, 8'h5A);
    add("a_d1",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D1,   8'h5A);
    add("a_d2",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D2,   8'h5A);
    add("a_done",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_DONE, 8'h5A);
    add("a_end",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_IDLE, 8'h5A);
    // 4b, len=3, valid held high: 6 back-to-back SHIFT cycles, ready on 2nd and 4th.
    add("b_idle",  1, 2'd1, 8'd3, 0, 8'h00, 8'h00, E_IDLE, 8'h5A);
    add("b_clr",   0, 2'd0, 8'd0, 1, 8'h70, 8'h99, E_CLR,  8'h5A);
    add("b_wait",  0, 2'd0, 8'd0, 1, 8'h70, 8'h11, E_WAIT, 8'h5A);
    add("b_sh1",   0, 2'd0, 8'd0, 1, 8'h70, 8'h99, 10'b1010100011, 8'h11);
    add("b_sh2",   0, 2'd0, 8'd0, 1, 8'h70, 8'h22, 10'b1011011001, 8'h11);
    add("b_sh3",   0, 2'd0, 8'd0, 1, 8'h70, 8'h99, 10'b1010100011, 8'h22);
    add("b_sh4",   0, 2'd0, 8'd0, 1, 8'h70, 8'h33, 10'b1011011001, 8'h22);
    add("b_sh5",   0, 2'd0, 8'd0, 1, 8'h70, 8'h99, 10'b1010100011, 8'h33);
    add("b_sh6",   0, 2'd0, 8'd0, 1, 8'h70, 8'h44, 10'b1011010001, 8'h33);
    add("b_d1",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D1,   8'h33);
    add("b_d2",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D2,   8'h33);
    add("b_done",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_DONE, 8'h33);
    add("b_end",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_IDLE, 8'h33);
    // 2b, len=2, with a 5-cycle bubble between operations.
    add("c_idle",  1, 2'd3, 8'd2, 0, 8'h00, 8'h00, E_IDLE, 8'h33);
    add("c_clr",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_CLR,  8'h33);
    add("c_wait",  0, 2'd0, 8'd0, 1, 8'h80, 8'hFF, E_WAIT, 8'h33);
    add("c_op1",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1011111010, 8'hFF);
    add("c_bub1",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_WAIT, 8'hFF);
    add("c_bub2",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_WAIT, 8'hFF);
    add("c_bub3",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_WAIT, 8'hFF);
    add("c_bub4",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_WAIT, 8'hFF);
    add("c_bub5",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_WAIT, 8'hFF);
    add("c_wait2", 0, 2'd0, 8'd0, 1, 8'h80, 8'hFF, E_WAIT, 8'hFF);
    add("c_op2",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, 10'b1011110010, 8'hFF);
    add("c_d1",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D1,   8'hFF);
    add("c_d2",    0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_D2,   8'hFF);
    add("c_done",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_DONE, 8'hFF);
    add("c_end",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_IDLE, 8'hFF);
    // Illegal config 2 acts as 2b; acc_len=0 acts as 1; start while busy is ignored.
    add("d_idle",  1, 2'd2, 8'd0, 0, 8'h00, 8'h00, E_IDLE, 8'hFF);
    add("d_clr",   1, 2'd0, 8'd5, 0, 8'h00, 8'h00, E_CLR,  8'hFF);
    add("d_wait",  1, 2'd0, 8'd5, 1, 8'h40, 8'h07, E_WAIT, 8'hFF);
    add("d_op",    1, 2'd0, 8'd5, 0, 8'h00, 8'h00, 10'b1011110001, 8'h07);
    add("d_d1",    1, 2'd0, 8'd5, 0, 8'h00, 8'h00, E_D1,   8'h07);
    add("d_d2",    1, 2'd0, 8'd5, 0, 8'h00, 8'h00, E_D2,   8'h07);
    add("d_done",  0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_DONE, 8'h07);
    add("d_end",   0, 2'd0, 8'd0, 0, 8'h00, 8'h00, E_IDLE, 8'h07);

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("por_ctl", 32'(obs()), 32'(E_IDLE));
    check("por_a", 32'(a), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven vectors: drive just after posedge, compare on negedge.
    for (int k = 0; k < vecs.size(); k++) begin
      start    = vecs[k].st;
      config_w = vecs[k].cfg;
      acc_len  = vecs[k].len;
      in_valid = vecs[k].vld;
      w_in     = vecs[k].w;
      a_in     = vecs[k].aa;
      @(negedge clk);
      check({vecs[k].name, "_ctl"}, 32'(obs()), 32'(vecs[k].exp_ctl));
      check({vecs[k].name, "_a"}, 32'(a), 32'(vecs[k].exp_a));
      @(posedge clk);
      #1;
    end
    drive_idle();

    // Mid-SHIFT reset: abort immediately, no z_valid afterwards.
    start = 1'b1; config_w = 2'd0; acc_len = 8'd1;
    @(posedge clk); #1 start = 1'b0;           // now CLR
    @(posedge clk); #1 in_valid = 1'b1; w_in = 8'hB6; a_in = 8'hC3; // now WAIT
    @(posedge clk); #1 in_valid = 1'b0;        // now SHIFT i0
    @(posedge clk); #1;                        // SHIFT i1
    @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ctl", 32'(obs()), 32'(E_IDLE));
    check("rst_a", 32'(a), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    z_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (z_valid) z_seen++;
    end
    check("rst_no_z", 32'(z_seen), 32'h0);
    check("rst_post_ctl", 32'(obs()), 32'(E_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_serial_seq.md
Name: mac_serial_seq

Overview:
- Sequencer/driver for the bit-serial MAC datapath (top_mac_serial); the hardware counterpart of the bench stimulus process.
- Accepts parallel (w, a) operand pairs over a valid/ready handshake and feeds them to the MAC.
- Shifts w out LSB-first in N_WIDTH-bit chunks at the configured precision and generates fsm_accu, fsm_last, the accumulator clock enable and the mini-reset.
- Flags z_valid when a programmed-length accumulation has settled.

Parameters:
- W_WIDTH, 8, full weight width.
- A_WIDTH, 8, activation width.
- N_WIDTH, 2, serial chunk width.
- CONFIG_W_WIDTH, 2, precision config width.
- LEN_WIDTH, 8, accumulation-length counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse: begin a new accumulation batch (sampled only in IDLE).
- config_w  in  CONFIG_W_WIDTH  precision; 0 → 8b, 1 → 4b, 3 → 2b; sampled with start.
- acc_len  in  LEN_WIDTH  number of MAC operations in the batch; 0 treated as 1; sampled with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts the pair this cycle.
- w_in  in  W_WIDTH  signed weight, MSB-aligned (zero-padded LSBs).
- a_in  in  A_WIDTH  unsigned activation, MSB-aligned.
- mac_rst  out  1  MAC reset (active-high, as the MAC expects).
- mac_en  out  1  MAC main clock-gate enable.
- accu_en  out  1  accumulator clock-gate enable (trigger_accu).
- fsm_accu  out  1  first chunk of an operation.
- fsm_last  out  1  last chunk of an operation.
- w_serial  out  N_WIDTH  current weight chunk.
- a  out  A_WIDTH  held activation.
- busy  out  1  not IDLE.
- z_valid  out  1  one-cycle pulse: MAC z holds the final batch result.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE.
  - All outputs 0 except mac_rst=1.
  - Counters cleared.
  - Mid-operation reset aborts immediately; no z_valid is produced.
- Widths: W_ACT = W_WIDTH/(config_w+1); CHUNKS = W_ACT/N_WIDTH, giving 4/2/1 for config 0/1/3.
  - config_w=2 is illegal; it is treated as 3.
- Operand capture: shift register sr <= w_in >> (W_WIDTH-W_ACT); a <= a_in.
- States:
  - IDLE:
    - mac_rst=1, mac_en=0, in_ready=0.
    - start=1 → CLR; latch config and len.
  - CLR (1 cycle):
    - mac_rst=1, mac_en=1, accu_en=1.
    - Clears the MAC accumulator → WAIT.
  - WAIT:
    - in_ready=1, mac_en=0, all FSM outputs 0, w_serial=0.
    - Handshake (in_valid & in_ready) → capture operands → SHIFT, chunk index i=0.
  - SHIFT: one cycle per chunk.
    - mac_en=1.
    - w_serial=sr[N_WIDTH-1:0]; sr >>= N_WIDTH each cycle.
    - fsm_accu = (i==0); fsm_last = (i==CHUNKS-1); accu_en = (i==1) | (CHUNKS==1).
    - On the last chunk, ops_done increments.
      - If ops_done+1 < len: in_ready=1 in that same cycle.
        - Handshake → capture and restart SHIFT at i=0 with no bubble.
        - No handshake → WAIT.
      - Otherwise → DRAIN1.
  - DRAIN1: mac_en=1, accu_en=1 (flushes the final product into the accumulator), w_serial=0.
  - DRAIN2: mac_en=1, accu_en=0.
  - DONE (1 cycle): z_valid=1, mac_en=0 → IDLE.
    - z is held in IDLE until the next start because mac_rst=1 only gates via the next CLR. The MAC holds z while mac_en=0.
- Ordering and ignored inputs:
  - start is ignored unless in IDLE.
  - in_valid is ignored outside WAIT and the last SHIFT cycle.
  - w_in/a_in must be stable only in the handshake cycle.
- Bubbles (WAIT with in_valid=0) stall the MAC via mac_en=0; the partial state is preserved.

Test Plan:
- Reset: drive rst_n=0 for 3 cycles mid-SHIFT → next cycle busy=0, mac_rst=1, fsm_*=0, w_serial=0, no z_valid.
- 8b, len=1:
  - Stimulus: config_w=0, w_in=8'b1011_0110.
  - Response: 4 SHIFT cycles with w_serial=10,01,11,10.
  - fsm_accu only in cycle 1; fsm_last only in cycle 4; accu_en only in cycle 2.
  - z_valid exactly 3 cycles after the last chunk.
- 4b, len=3, in_valid held high:
  - Stimulus: config_w=1, w_in=8'b0111_0000.
  - Response: w_serial=11,01 repeated; 6 back-to-back SHIFT cycles with no WAIT.
  - in_ready high on cycles 2 and 4 only.
- 2b, len=2:
  - Stimulus: config_w=3, w_in=8'b1000_0000, a_in=8'hFF.
  - Response: each op is 1 cycle with fsm_accu=fsm_last=accu_en=1 and w_serial=10.
  - Against the MAC model, z equals 2*(-2*255) in aligned form.
- Bubble: len=2, in_valid dropped for 5 cycles between ops → mac_en=0 for those 5 cycles; the final z matches the no-bubble run.
- acc_len=0 → behaves as len=1; start pulsed while busy → ignored, and ops_done is unchanged.
